// File: rtl/self_detection_sequencer.sv
// Tray actuator self-detection sweep controller.
// Walks each actuator output in turn and ramps its drive level from zero
// until the tray sensor reacts or the level saturates. One reflection entry
// per action goes into a small dictionary, which can be read combinationally.
// Optional build macro: SD_SENSOR_DEBOUNCE_EN. When it is defined, a reaction
// needs the same nonzero sensor code on the last settle cycle and on the
// sample cycle.
module self_detection_sequencer #(
   parameter int N_ACT     = 2,
   parameter int ICOU_W    = 4,
   parameter int ICOU_STEP = 1,
   parameter int SETTLE    = 8,
   parameter int ADDR_W    = 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic                          abort_i,
   input  logic [1:0]                    sensor_i,
   input  logic [7:0]                    stray_station_i,
   output logic [N_ACT-1:0]              action_o,
   output logic [ICOU_W-1:0]             aicou_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [N_ACT-1:0]              fail_mask_o,
   input  logic [ADDR_W-1:0]             rd_addr_i,
   output logic [N_ACT+ICOU_W+10-1:0]    rd_data_o
);

   localparam int ENTRY_W = N_ACT + ICOU_W + 10;
   localparam int IDX_W   = (N_ACT > 1) ? $clog2(N_ACT) : 1;
   localparam int CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [ICOU_W:0]   MAX_LEVEL = {1'b0, {ICOU_W{1'b1}}};
   localparam logic [ICOU_W:0]   STEP_WIDE = (ICOU_W + 1)'(ICOU_STEP);
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(SETTLE - 1);
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_ACT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_RECORD,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ICOU_W-1:0]   aicou_q, aicou_d;
   logic [N_ACT-1:0]    failMask_q, failMask_d;
   logic [1:0]          capSensor_q, capSensor_d;
   logic [7:0]          capStation_q, capStation_d;
   logic [ENTRY_W-1:0]  dict_q [N_ACT];
   logic [ENTRY_W-1:0]  dict_d [N_ACT];

   logic [N_ACT-1:0]    actionVec;
   logic [ICOU_W:0]     nextLevel;
   logic                reaction;
   logic                active;

`ifdef SD_SENSOR_DEBOUNCE_EN
   logic [1:0]          sensorPrev_q, sensorPrev_d;
`endif

   // Decode which actuator is selected and whether a sweep is in progress
   always_comb begin
      actionVec = N_ACT'(1) << idx_q;
      active    = (state_q == S_DRIVE) || (state_q == S_SETTLE) ||
                  (state_q == S_SAMPLE) || (state_q == S_RECORD);
      nextLevel = {1'b0, aicou_q} + STEP_WIDE;
`ifdef SD_SENSOR_DEBOUNCE_EN
      reaction  = (sensor_i != 2'b00) && (sensor_i == sensorPrev_q);
`else
      reaction  = (sensor_i != 2'b00);
`endif
   end

   // Next-state logic for the sweep; an abort outside IDLE drops the entry in flight
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      aicou_d      = aicou_q;
      failMask_d   = failMask_q;
      capSensor_d  = capSensor_q;
      capStation_d = capStation_q;
      dict_d       = dict_q;
`ifdef SD_SENSOR_DEBOUNCE_EN
      sensorPrev_d = sensor_i;
`endif

      case (state_q)
         S_IDLE: begin
            if (start_i && !abort_i) begin
               state_d    = S_DRIVE;
               idx_d      = '0;
               failMask_d = '0;
               aicou_d    = '0;
            end
         end
         S_DRIVE: begin
            aicou_d = '0;
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SAMPLE: begin
            capStation_d = stray_station_i;
            if (reaction) begin
               capSensor_d = sensor_i;
               state_d     = S_RECORD;
            end else if (nextLevel > MAX_LEVEL) begin
               capSensor_d       = 2'b00;
               failMask_d[idx_q] = 1'b1;
               state_d           = S_RECORD;
            end else begin
               aicou_d = aicou_q + ICOU_W'(ICOU_STEP);
               cnt_d   = CNT_LOAD;
               state_d = S_SETTLE;
            end
         end
         S_RECORD: begin
            dict_d[idx_q] = {actionVec, aicou_q, capSensor_q, capStation_q};
            aicou_d       = '0;
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_DRIVE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_i && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         aicou_d    = '0;
         failMask_d = failMask_q;
         dict_d     = dict_q;
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         aicou_q      <= '0;
         failMask_q   <= '0;
         capSensor_q  <= '0;
         capStation_q <= '0;
         dict_q       <= '{default: '0};
`ifdef SD_SENSOR_DEBOUNCE_EN
         sensorPrev_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         aicou_q      <= aicou_d;
         failMask_q   <= failMask_d;
         capSensor_q  <= capSensor_d;
         capStation_q <= capStation_d;
         dict_q       <= dict_d;
`ifdef SD_SENSOR_DEBOUNCE_EN
         sensorPrev_q <= sensorPrev_d;
`endif
      end
   end

   // Drive the actuator interface and status outputs
   always_comb begin
      action_o    = active ? actionVec : '0;
      aicou_o     = aicou_q;
      busy_o      = active;
      done_o      = (state_q == S_DONE);
      fail_mask_o = failMask_q;
   end

   // Combinational dictionary read; out-of-range addresses read as zero
   always_comb begin
      rd_data_o = '0;
      if (int'(rd_addr_i) < N_ACT) begin
         rd_data_o = dict_q[rd_addr_i];
      end
   end

endmodule

// File: tb/tb_self_detection_sequencer.sv
// Self-checking bench for self_detection_sequencer.
// Sensor reactions are modelled as per-action thresholds on the drive level;
// expected entries, fail mask and done timing come from a level-walking model.
// The glitch scenario runs only when SD_SENSOR_DEBOUNCE_EN is defined.
module tb_self_detection_sequencer;

   localparam int SETTLE = 8;
   localparam int STEP   = 1;
   localparam int MAXL   = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [1:0]  sensor;
   logic [7:0]  station;
   logic [1:0]  action;
   logic [3:0]  aicou;
   logic        busy;
   logic        done;
   logic [1:0]  failMask;
   logic        rdAddr;
   logic [17:0] rdData;

   int          thr [2];
   logic [1:0]  sensVal [2];
   logic        glitch;

   int          checkCount = 0;
   int          passCount  = 0;
   int          doneCount  = 0;

   logic [17:0] expEntry [2];
   logic [1:0]  expFail;
   int          expDoneCycle;

   self_detection_sequencer dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .abort_i         (abort),
      .sensor_i        (sensor),
      .stray_station_i (station),
      .action_o        (action),
      .aicou_o         (aicou),
      .busy_o          (busy),
      .done_o          (done),
      .fail_mask_o     (failMask),
      .rd_addr_i       (rdAddr),
      .rd_data_o       (rdData)
   );

   always #5 clk = ~clk;

   // Tray sensor: reacts once the selected action reaches its threshold level
   assign sensor = glitch ? 2'b01 :
                   (action[0] && (int'(aicou) >= thr[0])) ? sensVal[0] :
                   (action[1] && (int'(aicou) >= thr[1])) ? sensVal[1] : 2'b00;

   // Count done pulses seen at each rising edge
   always @(posedge clk) begin
      if (done === 1'b1) doneCount <= doneCount + 1;
   end

   // Hard stop in case the bench itself gets stuck
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) tick();
   endtask

   task automatic pulseStart();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitDone(input int from, output int cyc);
      cyc = from;
      while (done !== 1'b1 && cyc < 2000) begin
         tick();
         cyc++;
      end
   endtask

   task automatic readEntry(input logic a, output logic [17:0] d);
      rdAddr = a;
      #1;
      d = rdData;
   endtask

   task automatic modelAction(input int t, input logic [1:0] v, output logic [3:0] lvl,
                              output logic [1:0] sens, output bit failed, output int levels);
      int level;
      level  = 0;
      levels = 1;
      while (1) begin
         if (level >= t) begin
            lvl = 4'(level); sens = v; failed = 1'b0;
            return;
         end
         if (level + STEP > MAXL) begin
            lvl = 4'(level); sens = 2'b00; failed = 1'b1;
            return;
         end
         level += STEP;
         levels++;
      end
   endtask

   task automatic buildExpectation();
      logic [3:0] lvl;
      logic [1:0] sens;
      logic [1:0] act;
      bit         failed;
      int         levels;
      int         total;
      total = 1;
      for (int i = 0; i < 2; i++) begin
         modelAction(thr[i], sensVal[i], lvl, sens, failed, levels);
         act         = 2'(1 << i);
         expEntry[i] = {act, lvl, sens, station};
         expFail[i]  = failed;
         total      += 2 + levels * (SETTLE + 1);
      end
      expDoneCycle = total;
   endtask

   task automatic test_reset();
      logic [17:0] d;
      rst = 1'b1;
      idleCycles(2);
      rst = 1'b0;
      checkCount++;
      if ({action, aicou, busy, done, failMask} !== 10'd0)
         $display("[TB] FAIL reset_outputs: got %b want 0", {action, aicou, busy, done, failMask});
      else passCount++;
      for (int a = 0; a < 2; a++) begin
         readEntry(a[0], d);
         checkCount++;
         if (d !== 18'd0) $display("[TB] FAIL reset_dict%0d: got %h want 0", a, d);
         else passCount++;
      end
   endtask

   task automatic test_threshold_sweep();
      int cyc;
      int doneBefore;
      logic [17:0] d;
      thr[0] = 3; sensVal[0] = 2'b01;
      thr[1] = 5; sensVal[1] = 2'b10;
      station = 8'hA5;
      idleCycles(2);
      doneBefore = doneCount;
      pulseStart();
      checkCount++;
      if (busy !== 1'b1 || action !== 2'b01)
         $display("[TB] FAIL drive_first: got busy=%b action=%b want busy=1 action=01", busy, action);
      else passCount++;
      waitDone(1, cyc);
      checkCount++;
      if (cyc !== 95) $display("[TB] FAIL thr_done_cycle: got %0d want 95", cyc);
      else passCount++;
      checkCount++;
      if (failMask !== 2'b00) $display("[TB] FAIL thr_fail_mask: got %b want 00", failMask);
      else passCount++;
      readEntry(1'b0, d);
      checkCount++;
      if (d !== {2'b01, 4'd3, 2'b01, 8'hA5}) $display("[TB] FAIL thr_dict0: got %h want %h", d, {2'b01, 4'd3, 2'b01, 8'hA5});
      else passCount++;
      readEntry(1'b1, d);
      checkCount++;
      if (d !== {2'b10, 4'd5, 2'b10, 8'hA5}) $display("[TB] FAIL thr_dict1: got %h want %h", d, {2'b10, 4'd5, 2'b10, 8'hA5});
      else passCount++;
      idleCycles(3);
      checkCount++;
      if (doneCount - doneBefore !== 1) $display("[TB] FAIL thr_done_pulses: got %0d want 1", doneCount - doneBefore);
      else passCount++;
      checkCount++;
      if ({busy, done, action, aicou} !== 8'd0)
         $display("[TB] FAIL thr_back_idle: got %b want 0", {busy, done, action, aicou});
      else passCount++;
   endtask

   task automatic test_no_reaction();
      int cyc;
      logic [17:0] d;
      thr[0] = 99; thr[1] = 99;
      sensVal[0] = 2'b11; sensVal[1] = 2'b11;
      station = 8'(($urandom));
      idleCycles(2);
      pulseStart();
      waitDone(1, cyc);
      checkCount++;
      if (cyc !== 293) $display("[TB] FAIL sat_done_cycle: got %0d want 293", cyc);
      else passCount++;
      checkCount++;
      if (failMask !== 2'b11) $display("[TB] FAIL sat_fail_mask: got %b want 11", failMask);
      else passCount++;
      readEntry(1'b0, d);
      checkCount++;
      if (d !== {2'b01, 4'd15, 2'b00, station}) $display("[TB] FAIL sat_dict0: got %h want %h", d, {2'b01, 4'd15, 2'b00, station});
      else passCount++;
      readEntry(1'b1, d);
      checkCount++;
      if (d !== {2'b10, 4'd15, 2'b00, station}) $display("[TB] FAIL sat_dict1: got %h want %h", d, {2'b10, 4'd15, 2'b00, station});
      else passCount++;
      idleCycles(2);
   endtask

   task automatic test_random_sweeps();
      int cyc;
      logic [17:0] d;
      for (int it = 0; it < 5; it++) begin
         for (int i = 0; i < 2; i++) begin
            thr[i]     = int'($urandom_range(0, 17));
            sensVal[i] = 2'($urandom_range(1, 3));
         end
         station = 8'($urandom);
         buildExpectation();
         idleCycles(2);
         pulseStart();
         waitDone(1, cyc);
         checkCount++;
         if (cyc !== expDoneCycle) $display("[TB] FAIL rand%0d_done_cycle: got %0d want %0d", it, cyc, expDoneCycle);
         else passCount++;
         checkCount++;
         if (failMask !== expFail) $display("[TB] FAIL rand%0d_fail_mask: got %b want %b", it, failMask, expFail);
         else passCount++;
         for (int a = 0; a < 2; a++) begin
            readEntry(a[0], d);
            checkCount++;
            if (d !== expEntry[a]) $display("[TB] FAIL rand%0d_dict%0d: got %h want %h", it, a, d, expEntry[a]);
            else passCount++;
         end
         idleCycles(2);
      end
   endtask

   task automatic test_start_ignored();
      int cyc;
      int doneBefore;
      logic [17:0] d;
      thr[0] = 2; sensVal[0] = 2'b10;
      thr[1] = 1; sensVal[1] = 2'b01;
      station = 8'h3C;
      buildExpectation();
      idleCycles(2);
      doneBefore = doneCount;
      pulseStart();
      cyc = 1;
      repeat (15) begin tick(); cyc++; end
      start = 1'b1;
      repeat (3) begin tick(); cyc++; end
      start = 1'b0;
      waitDone(cyc, cyc);
      checkCount++;
      if (cyc !== expDoneCycle) $display("[TB] FAIL busy_start_done_cycle: got %0d want %0d", cyc, expDoneCycle);
      else passCount++;
      readEntry(1'b0, d);
      checkCount++;
      if (d !== expEntry[0]) $display("[TB] FAIL busy_start_dict0: got %h want %h", d, expEntry[0]);
      else passCount++;
      idleCycles(2);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      checkCount++;
      if ({busy, action} !== 3'd0) $display("[TB] FAIL start_abort_idle: got %b want 0", {busy, action});
      else passCount++;
      idleCycles(4);
      checkCount++;
      if (busy !== 1'b0 || doneCount - doneBefore !== 1)
         $display("[TB] FAIL start_abort_stays: got busy=%b pulses=%0d want busy=0 pulses=1", busy, doneCount - doneBefore);
      else passCount++;
   endtask

   task automatic test_abort();
      int cyc;
      int doneBefore;
      logic [17:0] prior [2];
      logic [17:0] d;
      thr[0] = 1; sensVal[0] = 2'b11;
      thr[1] = 2; sensVal[1] = 2'b01;
      station = 8'h5A;
      buildExpectation();
      prior[0] = expEntry[0];
      prior[1] = expEntry[1];
      idleCycles(2);
      pulseStart();
      waitDone(1, cyc);
      idleCycles(2);
      thr[0] = 99; thr[1] = 99;
      station = 8'hFF;
      doneBefore = doneCount;
      pulseStart();
      cyc = 1;
      repeat (19) begin tick(); cyc++; end
      checkCount++;
      if (busy !== 1'b1 || action !== 2'b01)
         $display("[TB] FAIL abort_pre_busy: got busy=%b action=%b want busy=1 action=01", busy, action);
      else passCount++;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkCount++;
      if ({busy, done, action, aicou} !== 8'd0)
         $display("[TB] FAIL abort_idle: got %b want 0", {busy, done, action, aicou});
      else passCount++;
      idleCycles(10);
      checkCount++;
      if (busy !== 1'b0 || doneCount !== doneBefore)
         $display("[TB] FAIL abort_no_done: got busy=%b pulses=%0d want busy=0 pulses=0", busy, doneCount - doneBefore);
      else passCount++;
      checkCount++;
      if (failMask !== 2'b00) $display("[TB] FAIL abort_fail_mask: got %b want 00", failMask);
      else passCount++;
      for (int a = 0; a < 2; a++) begin
         readEntry(a[0], d);
         checkCount++;
         if (d !== prior[a]) $display("[TB] FAIL abort_dict%0d: got %h want %h", a, d, prior[a]);
         else passCount++;
      end
   endtask

   task automatic test_reset_mid_sweep();
      logic [17:0] d;
      thr[0] = 0; sensVal[0] = 2'b10;
      thr[1] = 99; sensVal[1] = 2'b10;
      station = 8'h77;
      idleCycles(2);
      pulseStart();
      repeat (24) tick();
      checkCount++;
      if (busy !== 1'b1 || action !== 2'b10)
         $display("[TB] FAIL rst_pre_busy: got busy=%b action=%b want busy=1 action=10", busy, action);
      else passCount++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkCount++;
      if ({action, aicou, busy, done, failMask} !== 10'd0)
         $display("[TB] FAIL rst_mid_outputs: got %b want 0", {action, aicou, busy, done, failMask});
      else passCount++;
      readEntry(1'b0, d);
      checkCount++;
      if (d !== 18'd0) $display("[TB] FAIL rst_mid_dict0: got %h want 0", d);
      else passCount++;
      idleCycles(2);
   endtask

`ifdef SD_SENSOR_DEBOUNCE_EN
   task automatic test_debounce();
      int cyc;
      logic [17:0] d;
      thr[0] = 4; sensVal[0] = 2'b01;
      thr[1] = 0; sensVal[1] = 2'b11;
      station = 8'hC3;
      idleCycles(2);
      pulseStart();
      repeat (27) tick();
      glitch = 1'b1;
      tick();
      glitch = 1'b0;
      waitDone(29, cyc);
      checkCount++;
      if (cyc !== 59) $display("[TB] FAIL deb_done_cycle: got %0d want 59", cyc);
      else passCount++;
      readEntry(1'b0, d);
      checkCount++;
      if (d !== {2'b01, 4'd4, 2'b01, 8'hC3}) $display("[TB] FAIL deb_dict0: got %h want %h", d, {2'b01, 4'd4, 2'b01, 8'hC3});
      else passCount++;
      idleCycles(2);
   endtask
`endif

   // Run every scenario in order, then report
   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      abort      = 1'b0;
      glitch     = 1'b0;
      station    = 8'h00;
      rdAddr     = 1'b0;
      thr[0]     = 99;
      thr[1]     = 99;
      sensVal[0] = 2'b01;
      sensVal[1] = 2'b01;
      test_reset();
      test_threshold_sweep();
      test_no_reaction();
      test_random_sweeps();
      test_start_ignored();
      test_abort();
      test_reset_mid_sweep();
`ifdef SD_SENSOR_DEBOUNCE_EN
      test_debounce();
`endif
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/self_detection_sequencer.md
Name: self_detection_sequencer

Overview:
Clocked controller that runs the tray actuator self-detection sweep. For each actuator output in turn, it ramps the drive level (aicou) from zero until a sensor reacts or the level saturates. It records one reflection entry per action into a small dictionary and reports completion and per-action failure. It sits between the station supervisor (start/abort) and the actuator driver (action/aicou), and reads the tray sensor and stray_station bus.

Parameters:
N_ACT, 2, number of actuator outputs; action is one-hot of this width.
ICOU_W, 4, drive-level width.
ICOU_STEP, 1, drive increment per level.
SETTLE, 8, cycles held at each level before the sensor is sampled (>=1).
ADDR_W, 1, dictionary read-address width; 2**ADDR_W >= N_ACT.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin sweep; sampled only in IDLE
abort  in  1  cancel sweep; any state
sensor  in  2  tray sensor code; nonzero = reaction
stray_station  in  8  tray station code, captured with the entry
action  out  N_ACT  one-hot actuator select; 0 when idle
aicou  out  ICOU_W  actuator drive level
busy  out  1  high from DRIVE through RECORD
done  out  1  one-cycle pulse at sweep end
fail_mask  out  N_ACT  bit i set = action i saturated with no reaction
rd_addr  in  ADDR_W  dictionary read index
rd_data  out  N_ACT+ICOU_W+10  {action, aicou, sensor, stray_station} of entry rd_addr; combinational read

Behaviour:
- Reset (clk edge with rst=1): state IDLE. action=0, aicou=0, busy=0, done=0, fail_mask=0, all dictionary entries=0, settle counter=0. rst has priority over everything.
- States: IDLE, DRIVE, SETTLE, SAMPLE, RECORD, DONE.
- IDLE:
  - start=1 -> DRIVE.
  - Clears fail_mask and sets action index=0.
  - Dictionary entries are held, not cleared.
- DRIVE (1 cycle):
  - action=1<<index, aicou=0, settle counter=SETTLE-1.
  - -> SETTLE.
- SETTLE: counter decrements each cycle; at 0 -> SAMPLE. Occupies exactly SETTLE cycles.
- SAMPLE (1 cycle), priority order:
  - sensor!=0 -> RECORD.
  - Else if aicou+ICOU_STEP would exceed 2**ICOU_W-1 -> RECORD, set fail_mask[index].
  - Else aicou+=ICOU_STEP, reload counter, -> SETTLE.
- RECORD (1 cycle):
  - dict[index] <= {action, aicou, sensor, stray_station} as sampled in SAMPLE. On failure, sensor field=2'b00 and aicou=max level reached.
  - aicou=0.
  - If index==N_ACT-1 -> DONE; else index+=1 -> DRIVE.
- DONE (1 cycle): done=1, action=0, aicou=0, busy=0. -> IDLE.
- Per-action cycle count: 1 (DRIVE) + L*(SETTLE+1) + 1 (RECORD), where L = number of levels visited.
- abort=1 in any non-IDLE state: next cycle IDLE, action=0, aicou=0, busy=0, no done pulse. The entry being written is dropped; completed entries and fail_mask bits are kept.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: abort wins, stays IDLE.
- Sensor changes during SETTLE are ignored; only the SAMPLE-cycle value matters.
- rd_addr >= N_ACT returns 0.

Optional Feature:
SD_SENSOR_DEBOUNCE_EN:
- Defined: a reaction requires sensor!=0 and equal to its value in the last SETTLE cycle (two consecutive identical nonzero samples). A mismatch counts as no reaction.
- Undefined: a single-cycle sample at SAMPLE decides; no extra register.

Test Plan:
- Reset mid-sweep (rst in SETTLE of action 1) -> next cycle action=0, aicou=0, busy=0, done=0, fail_mask=0, rd_data(0)=0.
- Defaults; sensor=2'b01 once aicou>=3 on action 0, sensor=2'b10 once aicou>=5 on action 1; stray_station=8'hA5:
  - dict0={2'b01,4'd3,2'b01,8'hA5}, dict1={2'b10,4'd5,2'b10,8'hA5}, fail_mask=0.
  - done pulses once, 95 cycles after the start edge (38+56+1).
- Sensor never reacts -> each action climbs 0..15, fail_mask=2'b11, dict entries hold aicou=4'd15 and sensor=0, done at cycle 2*146+1=293.
- abort asserted at cycle 20 -> IDLE at cycle 21, no done, dict0 unchanged from its prior value, action=0.
- start asserted during busy and simultaneously with abort in IDLE -> no restart, no state change.
- With SD_SENSOR_DEBOUNCE_EN: a 1-cycle sensor glitch aligned to SAMPLE at aicou=2 -> not recorded; a stable reaction from aicou=4 -> entry aicou=4.
